rob: RTL and testbench

ROB -- requirements
Module: rob

---
 rtl/rob.sv | 142 ++++++++++++++
 tb/tb_rob.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob.sv
// rob: superscalar reorder buffer; circular buffer with in-order dispatch and retire
// and out-of-order completion from the CDB.
`ifndef ROB_SZ
`define ROB_SZ 32
`endif
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif
`ifndef XLEN
`define XLEN 32
`endif

package rob_pkg;
    typedef struct packed {
        logic             valid;
        logic             complete;
        logic             halt;
        logic             precise_state_enable;
        logic [5:0]       t_idx;
        logic [5:0]       told_idx;
        logic [4:0]       ar_idx;
        logic [`XLEN-1:0] npc;
        logic [`XLEN-1:0] dest_value;
        logic [`XLEN-1:0] target_pc;
    } rob_packet_t;
endpackage

module rob
    import rob_pkg::*;
#(
    parameter int ROB_SZ = `ROB_SZ,
    parameter int WAYS   = `SUPERSCALAR_WAYS
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [WAYS-1:0]                        dispatch_valid,
    input  rob_packet_t [WAYS-1:0]                 dispatch_in,
    output logic [WAYS-1:0][$clog2(ROB_SZ)-1:0]    dispatch_rob_idx,
    output logic [$clog2(ROB_SZ):0]                free_slots,
    input  logic [WAYS-1:0]                        cdb_valid,
    input  logic [WAYS-1:0][$clog2(ROB_SZ)-1:0]    cdb_rob_idx,
    input  logic [WAYS-1:0][`XLEN-1:0]             cdb_value,
    input  logic [WAYS-1:0]                        cdb_pse,
    input  logic [WAYS-1:0][`XLEN-1:0]             cdb_target_pc,
    input  logic [WAYS-1:0]                        retire_valid,
    input  logic                                   br_recover_enable,
    output rob_packet_t [WAYS-1:0]                 retire_rob_out
);
    localparam int IW = $clog2(ROB_SZ);
    localparam int CW = IW + 1;

    rob_packet_t                mem [ROB_SZ];
    rob_packet_t [WAYS-1:0]     disp_pkt;
    logic [IW-1:0]              head, tail;
    logic [CW-1:0]              count, n_req, n_disp, n_ret;
    logic [ROB_SZ-1:0]          valid, complete, valid_nx, complete_nx;
    logic [WAYS-1:0][IW-1:0]    ret_idx;
    logic [WAYS-1:0]            ret_bad;

    assign free_slots = CW'(ROB_SZ) - count;

    always_comb begin
        n_req = '0;
        n_ret = '0;
        for (int i = 0; i < WAYS; i++) begin
            n_req = n_req + CW'(dispatch_valid[i]);
            n_ret = n_ret + CW'(retire_valid[i]);
        end
        n_disp = n_req > free_slots ? free_slots : n_req;
    end

    // Invalid slots expose no complete/halt/pse so the retire stage never acts on stale data.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            dispatch_rob_idx[i] = tail + IW'(i);
            ret_idx[i] = head + IW'(i);
            retire_rob_out[i] = mem[ret_idx[i]];
            retire_rob_out[i].valid = valid[ret_idx[i]];
            retire_rob_out[i].complete = valid[ret_idx[i]] & complete[ret_idx[i]];
            retire_rob_out[i].halt = valid[ret_idx[i]] & mem[ret_idx[i]].halt;
            retire_rob_out[i].precise_state_enable = valid[ret_idx[i]] & mem[ret_idx[i]].precise_state_enable;
            ret_bad[i] = retire_valid[i] & ~(valid[ret_idx[i]] & complete[ret_idx[i]]);
            disp_pkt[i] = dispatch_in[i];
            disp_pkt[i].valid = 1'b1;
            disp_pkt[i].complete = 1'b0;
            disp_pkt[i].precise_state_enable = 1'b0;
            disp_pkt[i].dest_value = '0;
            disp_pkt[i].target_pc = '0;
        end
    end

    // Dispatch only targets free slots and completion only valid ones, so they never collide.
    always_comb begin
        valid_nx = valid;
        complete_nx = complete;
        for (int i = 0; i < WAYS; i++)
            if (CW'(i) < n_ret) valid_nx[ret_idx[i]] = 1'b0;
        for (int i = 0; i < WAYS; i++)
            if (cdb_valid[i] && valid[cdb_rob_idx[i]]) complete_nx[cdb_rob_idx[i]] = 1'b1;
        for (int i = 0; i < WAYS; i++)
            if (CW'(i) < n_disp) begin
                valid_nx[dispatch_rob_idx[i]] = 1'b1;
                complete_nx[dispatch_rob_idx[i]] = 1'b0;
            end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            complete <= '0;
        end else if (br_recover_enable) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            complete <= '0;
        end else begin
            head <= head + n_ret[IW-1:0];
            tail <= tail + n_disp[IW-1:0];
            count <= count + n_disp - n_ret;
            valid <= valid_nx;
            complete <= complete_nx;
        end
    end

    // Payload needs no reset; later cdb ways overwrite earlier ones on the same index.
    always_ff @(posedge clock) begin
        for (int i = 0; i < WAYS; i++)
            if (CW'(i) < n_disp) mem[dispatch_rob_idx[i]] <= disp_pkt[i];
        for (int i = 0; i < WAYS; i++)
            if (cdb_valid[i] && valid[cdb_rob_idx[i]]) begin
                mem[cdb_rob_idx[i]].dest_value <= cdb_value[i];
                mem[cdb_rob_idx[i]].precise_state_enable <= cdb_pse[i];
                mem[cdb_rob_idx[i]].target_pc <= cdb_target_pc[i];
            end
    end

    assert property (@(posedge clock) disable iff (!reset_n) ret_bad == '0);
endmodule

// File: tb/tb_rob.sv
// tb_rob: directed table, corner sequences and a queue-based random model for rob.
module tb_rob;
    import rob_pkg::*;
    localparam int SZ = 32;
    localparam int W  = 3;

    typedef struct {
        int nd; bit cv; int cidx; int nr; bit fl;
        int free; int tail; logic [2:0] cm; int npc0;
    } vec_t;
    typedef struct { int idx; rob_packet_t p; } ment_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic [W-1:0] dispatch_valid, cdb_valid, cdb_pse, retire_valid;
    rob_packet_t [W-1:0] dispatch_in, retire_rob_out;
    logic [W-1:0][4:0] dispatch_rob_idx, cdb_rob_idx;
    logic [W-1:0][31:0] cdb_value, cdb_target_pc;
    logic [5:0] free_slots;
    logic br_recover_enable;
    int total = 0;
    int bad = 0;
    vec_t tab [12];
    ment_t q [$];
    int mh, tt;

    always #5 clock = ~clock;

    rob #(.ROB_SZ(SZ), .WAYS(W)) dut (
        .clock(clock), .reset_n(reset_n),
        .dispatch_valid(dispatch_valid), .dispatch_in(dispatch_in),
        .dispatch_rob_idx(dispatch_rob_idx), .free_slots(free_slots),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_value(cdb_value),
        .cdb_pse(cdb_pse), .cdb_target_pc(cdb_target_pc),
        .retire_valid(retire_valid), .br_recover_enable(br_recover_enable),
        .retire_rob_out(retire_rob_out)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] cm();
        for (int i = 0; i < W; i++) cm[i] = retire_rob_out[i].complete;
    endfunction

    function automatic rob_packet_t pk(input int idx);
        pk = '0;
        pk.t_idx = 6'(idx);
        pk.npc = 32'h1000 + 32'(4 * idx);
    endfunction

    task automatic clr();
        dispatch_valid = '0;
        dispatch_in = '0;
        cdb_valid = '0;
        cdb_rob_idx = '0;
        cdb_value = '0;
        cdb_pse = '0;
        cdb_target_pc = '0;
        retire_valid = '0;
        br_recover_enable = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clr();
    endtask

    task automatic disp(input int n, input int base);
        dispatch_valid = 3'((1 << n) - 1);
        for (int i = 0; i < W; i++) dispatch_in[i] = pk((base + i) % SZ);
    endtask

    task automatic cdb(input int w, input int idx);
        cdb_valid[w] = 1'b1;
        cdb_rob_idx[w] = 5'(idx);
        cdb_value[w] = 32'(idx * 7);
        cdb_target_pc[w] = 32'h4000 + 32'(idx);
    endtask

    task automatic do_reset();
        clr();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        tab[0]  = '{3, 0, 0, 0, 0, 29, 3,  3'b000, 'h1000};
        tab[1]  = '{0, 1, 1, 0, 0, 29, 3,  3'b010, 'h1000};
        tab[2]  = '{0, 1, 0, 0, 0, 29, 3,  3'b011, 'h1000};
        tab[3]  = '{0, 0, 0, 2, 0, 31, 3,  3'b000, 'h1008};
        tab[4]  = '{0, 1, 2, 0, 0, 31, 3,  3'b001, 'h1008};
        tab[5]  = '{0, 0, 0, 1, 0, 32, 3,  3'b000, 0};
        tab[6]  = '{3, 0, 0, 0, 0, 29, 6,  3'b000, 'h100C};
        tab[7]  = '{3, 0, 0, 0, 0, 26, 9,  3'b000, 'h100C};
        tab[8]  = '{3, 0, 0, 0, 0, 23, 12, 3'b000, 'h100C};
        tab[9]  = '{1, 0, 0, 0, 0, 22, 13, 3'b000, 'h100C};
        tab[10] = '{3, 1, 3, 0, 1, 32, 0,  3'b000, 0};
        tab[11] = '{3, 0, 0, 0, 0, 29, 3,  3'b000, 'h1000};

        do_reset();
        chk("rst_free", free_slots, 32);
        for (int i = 0; i < W; i++) chk("rst_idx", dispatch_rob_idx[i], i);
        chk("rst_cm", cm(), 0);

        tt = 0;
        for (int k = 0; k < 12; k++) begin
            disp(tab[k].nd, tt);
            if (tab[k].cv) cdb(0, tab[k].cidx);
            retire_valid = 3'((1 << tab[k].nr) - 1);
            br_recover_enable = tab[k].fl;
            tick();
            chk("tab_free", free_slots, tab[k].free);
            chk("tab_tail", dispatch_rob_idx[0], tab[k].tail);
            chk("tab_idx2", dispatch_rob_idx[2], (tab[k].tail + 2) % SZ);
            chk("tab_cm", cm(), tab[k].cm);
            if (tab[k].npc0 != 0) chk("tab_head_npc", retire_rob_out[0].npc, tab[k].npc0);
            tt = tab[k].tail;
        end

        do_reset();
        for (int k = 0; k < 10; k++) begin
            disp(3, 3 * k);
            if (k == 1) begin cdb(0, 0); cdb(1, 1); end
            tick();
        end
        chk("fill30_free", free_slots, 2);
        disp(1, 30);
        tick();
        chk("fill31_free", free_slots, 1);
        disp(3, 31);
        tick();
        chk("full_free", free_slots, 0);
        chk("full_tail", dispatch_rob_idx[0], 0);
        disp(3, 0);
        retire_valid = 3'b011;
        tick();
        chk("full_ret_free", free_slots, 2);
        chk("full_ret_tail", dispatch_rob_idx[0], 0);
        chk("full_ret_head", retire_rob_out[0].npc, 32'h1008);

        do_reset();
        for (int k = 0; k < 10; k++) begin disp(3, 3 * k); tick(); end
        for (int k = 0; k < 10; k++) begin
            for (int w = 0; w < W; w++) cdb(w, 3 * k + w);
            tick();
        end
        for (int k = 0; k < 10; k++) begin retire_valid = 3'b111; tick(); end
        chk("wrap_empty", free_slots, 32);
        for (int i = 0; i < W; i++) chk("wrap_idx", dispatch_rob_idx[i], (30 + i) % SZ);
        disp(3, 30);
        tick();
        chk("wrap_free", free_slots, 29);
        chk("wrap_head_npc", retire_rob_out[0].npc, 32'h1000 + 32'(4 * 30));
        cdb(0, 30); cdb(1, 31); cdb(2, 0);
        tick();
        chk("wrap_cm", cm(), 3'b111);
        retire_valid = 3'b111;
        tick();
        chk("wrap_ret_free", free_slots, 32);
        chk("wrap_ret_tail", dispatch_rob_idx[0], 1);
        chk("wrap_ret_cm", cm(), 0);

        do_reset();
        disp(3, 0);
        tick();
        disp(2, 3);
        tick();
        chk("arst_pre", free_slots, 27);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_free", free_slots, 32);
        chk("arst_cm", cm(), 0);
        chk("arst_valid", retire_rob_out[0].valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        q.delete();
        mh = 0;
        for (int c = 0; c < 3000; c++) begin
            int sz, nd, nr, lead, fr, tl;
            bit fl;
            ment_t e;
            sz = q.size();
            chk("r_free", free_slots, 32 - sz);
            for (int i = 0; i < W; i++) begin
                chk("r_idx", dispatch_rob_idx[i], (mh + sz + i) % SZ);
                if (i < sz) chk("r_pkt", retire_rob_out[i], q[i].p);
                else chk("r_inv", {retire_rob_out[i].valid, retire_rob_out[i].complete,
                                   retire_rob_out[i].halt, retire_rob_out[i].precise_state_enable}, 0);
            end
            nd = $urandom_range(0, 3);
            dispatch_valid = 3'((1 << nd) - 1);
            for (int i = 0; i < W; i++) begin
                dispatch_in[i].valid = 1'($urandom);
                dispatch_in[i].complete = 1'($urandom);
                dispatch_in[i].halt = ($urandom % 8 == 0);
                dispatch_in[i].precise_state_enable = 1'($urandom);
                dispatch_in[i].t_idx = 6'($urandom);
                dispatch_in[i].told_idx = 6'($urandom);
                dispatch_in[i].ar_idx = 5'($urandom);
                dispatch_in[i].npc = $urandom;
                dispatch_in[i].dest_value = $urandom;
                dispatch_in[i].target_pc = $urandom;
            end
            for (int w = 0; w < W; w++) begin
                cdb_valid[w] = 1'($urandom);
                if (sz > 0 && $urandom % 4 != 0) cdb_rob_idx[w] = 5'(q[$urandom_range(0, sz - 1)].idx);
                else cdb_rob_idx[w] = 5'($urandom);
                cdb_value[w] = $urandom;
                cdb_pse[w] = 1'($urandom);
                cdb_target_pc[w] = $urandom;
            end
            lead = 0;
            while (lead < sz && lead < W && q[lead].p.complete) lead++;
            nr = (lead > 0 && $urandom % 3 != 0) ? $urandom_range(1, lead) : 0;
            retire_valid = 3'((1 << nr) - 1);
            fl = ($urandom % 50 == 0);
            br_recover_enable = fl;
            fr = 32 - sz;
            tl = (mh + sz) % SZ;
            @(posedge clock);
            #1;
            if (fl) begin
                q.delete();
                mh = 0;
            end else begin
                for (int w = 0; w < W; w++)
                    if (cdb_valid[w])
                        for (int j = 0; j < q.size(); j++)
                            if (q[j].idx == int'(cdb_rob_idx[w])) begin
                                q[j].p.complete = 1'b1;
                                q[j].p.dest_value = cdb_value[w];
                                q[j].p.precise_state_enable = cdb_pse[w];
                                q[j].p.target_pc = cdb_target_pc[w];
                            end
                repeat (nr) void'(q.pop_front());
                mh = (mh + nr) % SZ;
                for (int i = 0; i < (nd < fr ? nd : fr); i++) begin
                    e.idx = (tl + i) % SZ;
                    e.p = dispatch_in[i];
                    e.p.valid = 1'b1;
                    e.p.complete = 1'b0;
                    e.p.precise_state_enable = 1'b0;
                    e.p.dest_value = '0;
                    e.p.target_pc = '0;
                    q.push_back(e);
                end
            end
            clr();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
